// File: rtl/ahb_matrix_out_stage2.sv
// Output stage of an AHB bus-matrix port: round-robin arbitration between two input ports.
// Define AHB_MATRIX_OUT_LOCK_EN to keep the grant across HMASTLOCK sequences.
module ahb_matrix_out_stage2 #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              sel_op0,
    input  logic              sel_op1,
    input  logic [ADDR_W-1:0] addr_op0,
    input  logic [ADDR_W-1:0] addr_op1,
    input  logic [1:0]        trans_op0,
    input  logic [1:0]        trans_op1,
    input  logic              write_op0,
    input  logic              write_op1,
    input  logic [2:0]        size_op0,
    input  logic [2:0]        size_op1,
    input  logic [2:0]        burst_op0,
    input  logic [2:0]        burst_op1,
    input  logic [3:0]        prot_op0,
    input  logic [3:0]        prot_op1,
    input  logic              lock_op0,
    input  logic              lock_op1,
    input  logic [DATA_W-1:0] wdata_op0,
    input  logic [DATA_W-1:0] wdata_op1,
    output logic              active_op0,
    output logic              active_op1,
    output logic              readyout_op,
    output logic [1:0]        resp_op,
    output logic [DATA_W-1:0] rdata_op,
    output logic              HSELM,
    output logic [ADDR_W-1:0] HADDRM,
    output logic [1:0]        HTRANSM,
    output logic              HWRITEM,
    output logic [2:0]        HSIZEM,
    output logic [2:0]        HBURSTM,
    output logic [3:0]        HPROTM,
    output logic              HMASTLOCKM,
    output logic [DATA_W-1:0] HWDATAM,
    output logic              HREADYMUXM,
    input  logic              HREADYOUTM,
    input  logic [1:0]        HRESPM,
    input  logic [DATA_W-1:0] HRDATAM
);

    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    logic [1:0]        addr_port, data_port, grant;
    logic              last_port, lock_hold, lock_nxt, hold_grant;
    logic [4:0]        beat_cnt, beat_nxt;
    logic              req0, req1, own_valid, own_p1;
    logic              own_sel, own_write, own_lock;
    logic [ADDR_W-1:0] own_addr, keep_addr;
    logic [1:0]        own_trans;
    logic [2:0]        own_size, own_burst, keep_size, keep_burst;
    logic [3:0]        own_prot, keep_prot;
    logic              keep_write;

    assign req0      = sel_op0 & trans_op0[1];
    assign req1      = sel_op1 & trans_op1[1];
    assign own_valid = |addr_port;
    assign own_p1    = addr_port[1];

    assign own_sel   = own_p1 ? sel_op1   : sel_op0;
    assign own_addr  = own_p1 ? addr_op1  : addr_op0;
    assign own_trans = own_p1 ? trans_op1 : trans_op0;
    assign own_write = own_p1 ? write_op1 : write_op0;
    assign own_size  = own_p1 ? size_op1  : size_op0;
    assign own_burst = own_p1 ? burst_op1 : burst_op0;
    assign own_prot  = own_p1 ? prot_op1  : prot_op0;
    assign own_lock  = own_p1 ? lock_op1  : lock_op0;

    // With no owner the address/control lines park on the last accepted transfer.
    assign HSELM      = own_valid & own_sel;
    assign HTRANSM    = own_valid ? own_trans : 2'b00;
    assign HMASTLOCKM = own_valid & own_lock;
    assign HADDRM     = own_valid ? own_addr  : keep_addr;
    assign HWRITEM    = own_valid ? own_write : keep_write;
    assign HSIZEM     = own_valid ? own_size  : keep_size;
    assign HBURSTM    = own_valid ? own_burst : keep_burst;
    assign HPROTM     = own_valid ? own_prot  : keep_prot;

    assign HWDATAM    = data_port[1] ? wdata_op1 : (data_port[0] ? wdata_op0 : '0);
    assign active_op0 = addr_port[0];
    assign active_op1 = addr_port[1];

    assign HREADYMUXM  = HREADYOUTM;
    assign readyout_op = HREADYOUTM;
    assign resp_op     = HRESPM;
    assign rdata_op    = HRDATAM;

    always_comb begin
        beat_nxt = beat_cnt;
        if (own_valid) begin
            if (own_trans == TR_NONSEQ) begin
                case (own_burst)
                    3'b010, 3'b011: beat_nxt = 5'd3;
                    3'b100, 3'b101: beat_nxt = 5'd7;
                    3'b110, 3'b111: beat_nxt = 5'd15;
                    default:        beat_nxt = 5'd0;
                endcase
            end else if (own_trans == TR_SEQ && beat_cnt != 5'd0) begin
                beat_nxt = beat_cnt - 5'd1;
            end
        end
    end

`ifdef AHB_MATRIX_OUT_LOCK_EN
    always_comb begin
        lock_nxt = lock_hold;
        if (own_valid) begin
            if (!own_lock)
                lock_nxt = 1'b0;
            else if (own_trans[1])
                lock_nxt = 1'b1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            lock_hold <= 1'b0;
        else if (HREADYOUTM)
            lock_hold <= lock_nxt;
    end
`else
    assign lock_hold = 1'b0;
    assign lock_nxt  = lock_hold;
`endif

    // SEQ/BUSY only pins the grant for undefined-length bursts; fixed bursts end on the count.
    assign hold_grant = own_valid &
                        ((beat_nxt != 5'd0) | lock_nxt |
                         (own_trans[0] & (own_burst[2:1] == 2'b00)));

    always_comb begin
        grant = 2'b00;
        if (hold_grant)
            grant = addr_port;
        else if (req0 && req1)
            grant = last_port ? 2'b01 : 2'b10;
        else if (req0)
            grant = 2'b01;
        else if (req1)
            grant = 2'b10;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_port  <= 2'b00;
            data_port  <= 2'b00;
            last_port  <= 1'b1;
            beat_cnt   <= 5'd0;
            keep_addr  <= '0;
            keep_write <= 1'b0;
            keep_size  <= 3'b000;
            keep_burst <= 3'b000;
            keep_prot  <= 4'h0;
        end else if (HREADYOUTM) begin
            addr_port <= grant;
            data_port <= addr_port & {2{HTRANSM[1]}};
            beat_cnt  <= beat_nxt;
            if (!hold_grant && grant != 2'b00)
                last_port <= grant[1];
            if (own_valid) begin
                keep_addr  <= own_addr;
                keep_write <= own_write;
                keep_size  <= own_size;
                keep_burst <= own_burst;
                keep_prot  <= own_prot;
            end
        end else if (HRESPM == 2'b01) begin
            beat_cnt <= 5'd0;
        end
    end

endmodule

// File: tb/tb_ahb_matrix_out_stage2.sv
// Directed bench for ahb_matrix_out_stage2 with a cycle-level behavioural model of the arbiter.
module tb_ahb_matrix_out_stage2;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;
    localparam logic [2:0] SINGLE = 3'd0, INCR = 3'd1, INCR4 = 3'd3, WRAP8 = 3'd4, INCR16 = 3'd7;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b1;
    always #5 HCLK = ~HCLK;

    logic          sel   [2];
    logic [AW-1:0] addr  [2];
    logic [1:0]    trans [2];
    logic          wr    [2];
    logic [2:0]    size  [2];
    logic [2:0]    burst [2];
    logic [3:0]    prot  [2];
    logic          lock  [2];
    logic [DW-1:0] wdata [2];

    logic          active_op0, active_op1, readyout_op;
    logic [1:0]    resp_op;
    logic [DW-1:0] rdata_op;
    logic          HSELM, HWRITEM, HMASTLOCKM, HREADYMUXM;
    logic [AW-1:0] HADDRM;
    logic [1:0]    HTRANSM;
    logic [2:0]    HSIZEM, HBURSTM;
    logic [3:0]    HPROTM;
    logic [DW-1:0] HWDATAM;
    logic          HREADYOUTM;
    logic [1:0]    HRESPM;
    logic [DW-1:0] HRDATAM;

    ahb_matrix_out_stage2 #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .sel_op0(sel[0]), .sel_op1(sel[1]),
        .addr_op0(addr[0]), .addr_op1(addr[1]),
        .trans_op0(trans[0]), .trans_op1(trans[1]),
        .write_op0(wr[0]), .write_op1(wr[1]),
        .size_op0(size[0]), .size_op1(size[1]),
        .burst_op0(burst[0]), .burst_op1(burst[1]),
        .prot_op0(prot[0]), .prot_op1(prot[1]),
        .lock_op0(lock[0]), .lock_op1(lock[1]),
        .wdata_op0(wdata[0]), .wdata_op1(wdata[1]),
        .active_op0(active_op0), .active_op1(active_op1),
        .readyout_op(readyout_op), .resp_op(resp_op), .rdata_op(rdata_op),
        .HSELM(HSELM), .HADDRM(HADDRM), .HTRANSM(HTRANSM), .HWRITEM(HWRITEM),
        .HSIZEM(HSIZEM), .HBURSTM(HBURSTM), .HPROTM(HPROTM), .HMASTLOCKM(HMASTLOCKM),
        .HWDATAM(HWDATAM), .HREADYMUXM(HREADYMUXM),
        .HREADYOUTM(HREADYOUTM), .HRESPM(HRESPM), .HRDATAM(HRDATAM)
    );

    int n_vec = 0;
    int n_err = 0;
    bit run = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: owner/data owner as port numbers (-1 = none), beats left in the current burst.
    int            m_own = -1, m_dat = -1, m_left = 0, m_last = 1;
    bit            m_lk = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic          m_wr = 1'b0;
    logic [2:0]    m_size = '0, m_burst = '0;
    logic [3:0]    m_prot = '0;

    function automatic int beats(input logic [2:0] b);
        case (b)
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            3'd6, 3'd7: return 16;
            default:    return 1;
        endcase
    endfunction

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            m_own = -1; m_dat = -1; m_left = 0; m_last = 1; m_lk = 1'b0;
            m_addr = '0; m_wr = 1'b0; m_size = '0; m_burst = '0; m_prot = '0;
        end else if (HREADYOUTM) begin
            int  p;
            bit  keep;
            bit  r0, r1;
            p = m_own;
            m_dat = -1;
            keep = 1'b0;
            if (p >= 0) begin
                if (trans[p] == NSEQ) m_left = beats(burst[p]) - 1;
                else if (trans[p] == SEQ && m_left > 0) m_left = m_left - 1;
`ifdef AHB_MATRIX_OUT_LOCK_EN
                if (!lock[p]) m_lk = 1'b0;
                else if (trans[p] == NSEQ || trans[p] == SEQ) m_lk = 1'b1;
`endif
                if (trans[p] == NSEQ || trans[p] == SEQ) m_dat = p;
                m_addr = addr[p]; m_wr = wr[p]; m_size = size[p];
                m_burst = burst[p]; m_prot = prot[p];
                keep = (m_left > 0) || m_lk ||
                       ((trans[p] == SEQ || trans[p] == BUSY) && (burst[p] == SINGLE || burst[p] == INCR));
            end
            if (!keep) begin
                r0 = sel[0] && trans[0][1];
                r1 = sel[1] && trans[1][1];
                if (r0 && r1) m_own = 1 - m_last;
                else if (r0)  m_own = 0;
                else if (r1)  m_own = 1;
                else          m_own = -1;
                if (m_own >= 0) m_last = m_own;
            end
        end else if (HRESPM == 2'b01) begin
            m_left = 0;
        end
    end

    always @(negedge HCLK) begin
        if (run) begin
            logic          e_sel, e_wr, e_lk;
            logic [AW-1:0] e_addr;
            logic [1:0]    e_tr;
            logic [2:0]    e_sz, e_bu;
            logic [3:0]    e_pr;
            logic [DW-1:0] e_wd;
            e_sel = 1'b0; e_tr = IDLE; e_lk = 1'b0;
            e_addr = m_addr; e_wr = m_wr; e_sz = m_size; e_bu = m_burst; e_pr = m_prot;
            if (m_own >= 0) begin
                e_sel = sel[m_own]; e_tr = trans[m_own]; e_lk = lock[m_own];
                e_addr = addr[m_own]; e_wr = wr[m_own]; e_sz = size[m_own];
                e_bu = burst[m_own]; e_pr = prot[m_own];
            end
            e_wd = (m_dat >= 0) ? wdata[m_dat] : '0;
            chk("active_op0", active_op0, m_own == 0);
            chk("active_op1", active_op1, m_own == 1);
            chk("HSELM", HSELM, e_sel);
            chk("HTRANSM", HTRANSM, e_tr);
            chk("HMASTLOCKM", HMASTLOCKM, e_lk);
            chk("HADDRM", HADDRM, e_addr);
            chk("HWRITEM", HWRITEM, e_wr);
            chk("HSIZEM", HSIZEM, e_sz);
            chk("HBURSTM", HBURSTM, e_bu);
            chk("HPROTM", HPROTM, e_pr);
            chk("HWDATAM", HWDATAM, e_wd);
            chk("readyout_op", readyout_op, HREADYOUTM);
            chk("HREADYMUXM", HREADYMUXM, HREADYOUTM);
            chk("resp_op", resp_op, HRESPM);
            chk("rdata_op", rdata_op, HRDATAM);
        end
    end

    task automatic nxt();
        @(posedge HCLK);
        #1;
    endtask

    task automatic set_p(input int p, input logic s, input logic [1:0] t, input logic [AW-1:0] a,
                         input logic w, input logic [2:0] b, input logic l);
        sel[p] = s; trans[p] = t; addr[p] = a; wr[p] = w; burst[p] = b; lock[p] = l;
        size[p] = (p == 0) ? 3'd2 : 3'd1;
        prot[p] = (p == 0) ? 4'hA : 4'h3;
    endtask

    task automatic idle_p(input int p);
        set_p(p, 1'b0, IDLE, '0, 1'b0, SINGLE, 1'b0);
    endtask

    initial begin
        for (int p = 0; p < 2; p++) begin
            idle_p(p);
            wdata[p] = '0;
        end
        HREADYOUTM = 1'b1; HRESPM = 2'b00; HRDATAM = '0;
        #1 HRESETn = 1'b0;
        run = 1'b1;
        nxt(); nxt();
        @(negedge HCLK);
        chk("rst_active0", active_op0, 1'b0);
        chk("rst_hselm", HSELM, 1'b0);
        chk("rst_haddrm", HADDRM, 32'h0);
        chk("rst_hwdatam", HWDATAM, 32'h0);
        nxt();
        HRESETn = 1'b1;
        nxt();

        // single read from port 0
        set_p(0, 1'b1, NSEQ, 32'h4000_0010, 1'b0, SINGLE, 1'b0);
        nxt();
        @(negedge HCLK);
        chk("t1_active0", active_op0, 1'b1);
        chk("t1_haddr", HADDRM, 32'h4000_0010);
        chk("t1_htrans", HTRANSM, 2'b10);
        nxt();
        idle_p(0);
        HRDATAM = 32'h1234_5678;
        @(negedge HCLK);
        chk("t1_rdata", rdata_op, 32'h1234_5678);
        nxt(); nxt();

        // both ports issue SINGLEs every cycle
        for (int i = 0; i < 6; i++) begin
            set_p(0, 1'b1, NSEQ, 32'h1000 + 32'(i * 4), 1'b0, SINGLE, 1'b0);
            set_p(1, 1'b1, NSEQ, 32'h2000 + 32'(i * 4), 1'b1, SINGLE, 1'b0);
            @(negedge HCLK);
            if (i >= 1) chk("t2_active1", active_op1, (i % 2) == 1);
            if (i >= 2) chk("t2_active0", active_op0, (i % 2) == 0);
            nxt();
        end
        idle_p(0); idle_p(1);
        nxt(); nxt();

        // INCR4 write from port 0 while port 1 waits
        set_p(0, 1'b1, NSEQ, 32'h100, 1'b1, INCR4, 1'b0);
        nxt();
        set_p(1, 1'b1, NSEQ, 32'h2F0, 1'b0, SINGLE, 1'b0);
        @(negedge HCLK);
        chk("t3_active0", active_op0, 1'b1);
        nxt();
        for (int b = 1; b < 4; b++) begin
            set_p(0, 1'b1, SEQ, 32'h100 + 32'(b * 4), 1'b1, INCR4, 1'b0);
            wdata[0] = 32'hA000_0000 + 32'(b);
            @(negedge HCLK);
            chk("t3_active1", active_op1, 1'b0);
            chk("t3_hwdata", HWDATAM, 32'hA000_0000 + 32'(b));
            nxt();
        end
        idle_p(0);
        wdata[0] = 32'hA000_0004;
        @(negedge HCLK);
        chk("t3_active1_end", active_op1, 1'b1);
        chk("t3_hwdata4", HWDATAM, 32'hA000_0004);
        chk("t3_haddr", HADDRM, 32'h2F0);
        nxt();

        // INCR4 read from port 1 with three wait states mid-burst
        set_p(1, 1'b1, NSEQ, 32'h200, 1'b0, INCR4, 1'b0);
        nxt();
        set_p(1, 1'b1, SEQ, 32'h204, 1'b0, INCR4, 1'b0);
        set_p(0, 1'b1, NSEQ, 32'h300, 1'b0, SINGLE, 1'b0);
        nxt();
        set_p(1, 1'b1, SEQ, 32'h208, 1'b0, INCR4, 1'b0);
        HREADYOUTM = 1'b0;
        HRDATAM = 32'hBEEF_0001;
        for (int w = 0; w < 3; w++) begin
            @(negedge HCLK);
            chk("t4_wait_active1", active_op1, 1'b1);
            chk("t4_wait_haddr", HADDRM, 32'h208);
            chk("t4_wait_ready", readyout_op, 1'b0);
            nxt();
        end
        HREADYOUTM = 1'b1;
        @(negedge HCLK);
        chk("t4_active0_a", active_op0, 1'b0);
        nxt();
        set_p(1, 1'b1, SEQ, 32'h20C, 1'b0, INCR4, 1'b0);
        @(negedge HCLK);
        chk("t4_active0_b", active_op0, 1'b0);
        nxt();
        idle_p(1);
        @(negedge HCLK);
        chk("t4_active0_c", active_op0, 1'b1);
        chk("t4_haddr", HADDRM, 32'h300);
        nxt();

        // WRAP8 from port 0 cut short by an ERROR response
        set_p(0, 1'b1, NSEQ, 32'h400, 1'b0, WRAP8, 1'b0);
        nxt();
        set_p(0, 1'b1, SEQ, 32'h404, 1'b0, WRAP8, 1'b0);
        set_p(1, 1'b1, NSEQ, 32'h500, 1'b1, SINGLE, 1'b0);
        nxt();
        set_p(0, 1'b1, SEQ, 32'h408, 1'b0, WRAP8, 1'b0);
        HREADYOUTM = 1'b0; HRESPM = 2'b01;
        @(negedge HCLK);
        chk("t6_resp", resp_op, 2'b01);
        nxt();
        HREADYOUTM = 1'b1;
        idle_p(0);
        @(negedge HCLK);
        chk("t6_active0", active_op0, 1'b1);
        nxt();
        HRESPM = 2'b00;
        @(negedge HCLK);
        chk("t6_active1", active_op1, 1'b1);
        chk("t6_haddr", HADDRM, 32'h500);
        nxt();
        idle_p(1);
        nxt(); nxt();

        // locked SINGLEs from port 1 with port 0 requesting
        set_p(1, 1'b1, NSEQ, 32'h600, 1'b1, SINGLE, 1'b1);
        nxt();
        set_p(0, 1'b1, NSEQ, 32'h700, 1'b0, SINGLE, 1'b0);
        @(negedge HCLK);
        chk("t5_active1", active_op1, 1'b1);
        chk("t5_lock", HMASTLOCKM, 1'b1);
        nxt();
        set_p(1, 1'b1, NSEQ, 32'h604, 1'b1, SINGLE, 1'b1);
        @(negedge HCLK);
`ifdef AHB_MATRIX_OUT_LOCK_EN
        chk("t5_locked_owner", active_op1, 1'b1);
`else
        chk("t5_unlocked_owner", active_op0, 1'b1);
`endif
        nxt();
        idle_p(1);
        nxt();
        @(negedge HCLK);
        chk("t5_active0_end", active_op0, 1'b1);
        nxt();
        idle_p(0);
        nxt(); nxt();

        // reset in the middle of an INCR16
        set_p(0, 1'b1, NSEQ, 32'h800, 1'b1, INCR16, 1'b0);
        nxt(); nxt();
        set_p(0, 1'b1, SEQ, 32'h804, 1'b1, INCR16, 1'b0);
        wdata[0] = 32'hC0DE_0001;
        @(negedge HCLK);
        chk("t7_active0", active_op0, 1'b1);
        #2 HRESETn = 1'b0;
        #1;
        chk("t7_rst_active0", active_op0, 1'b0);
        chk("t7_rst_hselm", HSELM, 1'b0);
        chk("t7_rst_hwdata", HWDATAM, 32'h0);
        idle_p(0);
        nxt();
        HRESETn = 1'b1;
        set_p(0, 1'b1, NSEQ, 32'h900, 1'b0, SINGLE, 1'b0);
        set_p(1, 1'b1, NSEQ, 32'hA00, 1'b0, SINGLE, 1'b0);
        nxt();
        @(negedge HCLK);
        chk("t7_first_winner", active_op0, 1'b1);
        nxt();
        idle_p(0); idle_p(1);
        nxt(); nxt(); nxt();

        run = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
